core_irq_dispatch: RTL

//  Core-side responder to the DPS interrupt controller. Accepts IRQ_VALID/IRQ_NUM, drains
//  the pipeline, returns the one-cycle IRQ_ACK, fetches the handler entry from the interrupt

---
 rtl/core_irq_dispatch.sv | 107 ++++++++++
 1 files changed

// File: rtl/core_irq_dispatch.sv
// Core-side interrupt responder: drains the pipeline, acknowledges the IRQ,
// fetches the handler from the IDT and issues the jump with the saved PC.
module core_irq_dispatch #(
    parameter int P_NUM_W  = 1,
    parameter int P_ADDR_W = 32
) (
    input  logic                iCLOCK,
    input  logic                iRESET_SYNC,
    input  logic                iIRQ_VALID,
    input  logic [P_NUM_W-1:0]  iIRQ_NUM,
    output logic                oIRQ_ACK,
    input  logic                iPSR_IE,
    input  logic                iEXCEPT_BUSY,
    output logic                oFLUSH_REQ,
    input  logic                iFLUSH_DONE,
    input  logic [P_ADDR_W-1:0] iCURRENT_PC,
    input  logic [P_ADDR_W-1:0] iIDT_BASE,
    output logic                oIDT_REQ,
    output logic [P_ADDR_W-1:0] oIDT_ADDR,
    input  logic                iIDT_BUSY,
    input  logic                iIDT_VALID,
    input  logic [P_ADDR_W-1:0] iIDT_DATA,
    output logic                oJUMP_VALID,
    output logic [P_ADDR_W-1:0] oJUMP_ADDR,
    output logic [P_ADDR_W-1:0] oSAVE_PC,
    input  logic                iJUMP_ACK,
    output logic                oFAULT,
    output logic                oBUSY
);

    typedef enum logic [2:0] {
        IDLE, FLUSH, ACK, IDTREQ, IDTWAIT, JUMP, FAULT
    } stateT;

    stateT                  state;
    logic [P_NUM_W-1:0]     numQ;
    logic [P_ADDR_W-1:0]    pcQ;
    logic [P_ADDR_W-1:0]    idtAddrQ;
    logic [P_ADDR_W-1:2]    handlerQ;
    logic                   unusedIdtBit;

    // Entry bit 1 is reserved and carries no meaning here.
    assign unusedIdtBit = iIDT_DATA[1];

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state    <= IDLE;
            numQ     <= '0;
            pcQ      <= '0;
            idtAddrQ <= '0;
            handlerQ <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (iIRQ_VALID && iPSR_IE && !iEXCEPT_BUSY) begin
                        numQ  <= iIRQ_NUM;
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (iFLUSH_DONE) begin
                        pcQ   <= iCURRENT_PC;
                        state <= ACK;
                    end
                end
                ACK: begin
                    idtAddrQ <= iIDT_BASE + (P_ADDR_W'(numQ) << 3);
                    state    <= IDTREQ;
                end
                IDTREQ: begin
                    if (!iIDT_BUSY) begin
                        state <= IDTWAIT;
                    end
                end
                IDTWAIT: begin
                    if (iIDT_VALID) begin
                        handlerQ <= iIDT_DATA[P_ADDR_W-1:2];
                        state    <= iIDT_DATA[0] ? JUMP : FAULT;
                    end
                end
                JUMP: begin
                    if (iJUMP_ACK) begin
                        state <= IDLE;
                    end
                end
                FAULT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign oFLUSH_REQ  = (state == FLUSH);
    assign oIRQ_ACK    = (state == ACK);
    assign oIDT_REQ    = (state == IDTREQ);
    assign oJUMP_VALID = (state == JUMP);
    assign oFAULT      = (state == FAULT);
    assign oBUSY       = (state != IDLE);

    assign oIDT_ADDR  = oIDT_REQ ? idtAddrQ : '0;
    assign oJUMP_ADDR = oJUMP_VALID ? {handlerQ, 2'b00} : '0;
    assign oSAVE_PC   = (oJUMP_VALID || oFAULT) ? pcQ : '0;

endmodule
